// File: rtl/pwm_leds_if.sv
// Peripheral bus bundle between the CPU and the LED controller.
// Latency: read_data/response are combinational from the request.
// Backpressure: none; every access completes in the cycle it is issued.
interface pwm_leds_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;

    modport master (
        output read, write, address, write_data,
        input  read_data, response
    );

    modport slave (
        input  read, write, address, write_data,
        output read_data, response
    );
endinterface

// File: rtl/pwm_leds.sv
// Memory-mapped LED controller: per-channel enable, PWM brightness, optional blink (LEDS_BLINK_EN).
// Latency: reads combinational, writes land on the edge, leds follow one edge later.
// Backpressure: none; response = read | write every cycle, zero wait states.
module pwm_leds #(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    pwm_leds_if.slave           bus,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [NUM_LEDS-1:0] DARK = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [4:0] IDX_OUT    = 5'd0;
    localparam logic [4:0] IDX_MASK   = 5'd1;
    localparam logic [4:0] IDX_PERIOD = 5'd2;
    localparam logic [4:0] IDX_STATUS = 5'd3;
    localparam int         IDX_DUTY0  = 8;

    logic [4:0]          idx;
    logic [NUM_LEDS-1:0] out_q;
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] blink_mask;
    logic [31:0]         blink_period;
    logic                phase;
    logic [NUM_LEDS-1:0] lit;
    logic [31:0]         rd;

    assign idx = bus.address[6:2];

    // Only a handful of address/data bits are decoded; the rest are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.address, bus.write_data};

    // Channel enable and per-channel duty registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= '1;
            end
        end else if (bus.write) begin
            if (idx == IDX_OUT) begin
                out_q <= bus.write_data[NUM_LEDS-1:0];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (idx == 5'(IDX_DUTY0 + i)) begin
                    duty_q[i] <= bus.write_data[PWM_BITS-1:0];
                end
            end
        end
    end

    // Free-running PWM counter, wraps naturally at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

`ifdef LEDS_BLINK_EN
    logic [NUM_LEDS-1:0] blink_mask_q;
    logic [31:0]         blink_period_q;
    logic [31:0]         prescaler;
    logic                phase_q;

    assign blink_mask   = blink_mask_q;
    assign blink_period = blink_period_q;
    assign phase        = phase_q;

    // Blink configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_mask_q   <= '0;
            blink_period_q <= '0;
        end else if (bus.write) begin
            if (idx == IDX_MASK) begin
                blink_mask_q <= bus.write_data[NUM_LEDS-1:0];
            end
            if (idx == IDX_PERIOD) begin
                blink_period_q <= bus.write_data;
            end
        end
    end

    // Half-period prescaler; a period rewrite restarts the lit half immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            phase_q   <= 1'b1;
        end else if (bus.write && (idx == IDX_PERIOD)) begin
            prescaler <= '0;
            phase_q   <= 1'b1;
        end else if (blink_period_q == 32'd0) begin
            prescaler <= '0;
            phase_q   <= 1'b1;
        end else if (prescaler == blink_period_q - 32'd1) begin
            prescaler <= '0;
            phase_q   <= ~phase_q;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end
`else
    // Without blink hardware the lit phase is permanent and the blink registers read as zero.
    assign blink_mask   = '0;
    assign blink_period = '0;
    assign phase        = 1'b1;
`endif

    // Per-channel lit decision: enable, PWM window and blink gating.
    always_comb begin
        lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            lit[i] = out_q[i]
                   & ((duty_q[i] == '1) | (pwm_cnt < duty_q[i]))
                   & (~blink_mask[i] | phase);
        end
    end

    // Registered pin drive with polarity applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds <= DARK;
        end else begin
            leds <= lit ^ DARK;
        end
    end

    // Combinational read mux; returns pre-write values when read and write coincide.
    always_comb begin
        rd = '0;
        if (bus.read) begin
            case (idx)
                IDX_OUT:    rd[NUM_LEDS-1:0] = out_q;
                IDX_MASK:   rd[NUM_LEDS-1:0] = blink_mask;
                IDX_PERIOD: rd               = blink_period;
                IDX_STATUS: rd = {16'(NUM_LEDS), 8'(PWM_BITS), 7'd0, phase};
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (idx == 5'(IDX_DUTY0 + i)) begin
                            rd[PWM_BITS-1:0] = duty_q[i];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.read_data = rd;
    assign bus.response  = bus.read | bus.write;

endmodule
